// File: rtl/vga_pkg.sv
// Shared VGA screen geometry and the pixel record carried from scanner to framebuffer.
package vga_pkg;

    localparam int SCR_W    = 160;
    localparam int SCR_H    = 120;
    localparam int COLOUR_W = 12;
    localparam int COORD_W  = 8;
    localparam int VGA_Y_W  = 7;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/plot_fifo.sv
// DEPTH-entry synchronous pixel FIFO with full, empty and occupancy count.
// The caller gates push with !full and pop with !empty; this block does not re-check.
module plot_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  pixel_t                 wdata,
    input  logic                   pop,
    output pixel_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pixel_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    // Pointer and occupancy state; storage contents are left unreset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/plot_writer.sv
// Buffers scanner pixels and issues one-cycle framebuffer plot strobes.
// Optional feature: define PLOT_WRITER_CLIP_EN to drop off-screen pixels
// at push time and count them on drop_count.
module plot_writer
    import vga_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int X_MAX = SCR_W - 1,
    parameter int Y_MAX = SCR_H - 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [COORD_W-1:0]  in_x,
    input  logic [COORD_W-1:0]  in_y,
    input  logic [COLOUR_W-1:0] in_color,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                vga_ready,
    output logic [COORD_W-1:0]  vga_x,
    output logic [VGA_Y_W-1:0]  vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                frame_done
`ifdef PLOT_WRITER_CLIP_EN
    ,
    output logic [7:0]          drop_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    pixel_t                fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_cnt;
    logic                  accept, store, pop_fire;
    logic                  run_q, run_d;
    logic [COORD_W-1:0]    x_q, x_d;
    logic [VGA_Y_W-1:0]    y_q, y_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic                  plot_q, plot_d;
    logic                  frame_q, frame_d;

    // Handshake and push/pop decisions; clipped pixels are consumed but never stored.
`ifdef PLOT_WRITER_CLIP_EN
    logic       oob;
    logic [7:0] drop_q, drop_d;
    always_comb begin
        oob    = (in_x > COORD_W'(X_MAX)) || (in_y > COORD_W'(Y_MAX));
        drop_d = drop_q;
        if (accept && oob && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
    assign store      = accept && !oob && !fifo_full;
    assign drop_count = drop_q;
`else
    assign store = accept && !fifo_full;
`endif

    // in_ready stays low until the first edge after reset, then tracks not-full.
    assign in_ready = run_q && (fifo_cnt < CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign pop_fire = vga_ready && !fifo_empty;
    assign run_d    = 1'b1;

    plot_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (store),
        .wdata  ('{x: in_x, y: in_y, colour: in_color}),
        .pop    (pop_fire),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_cnt)
    );

    // Output register: load from the head on a pop, otherwise hold with strobes low.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = pop_fire;
        frame_d  = 1'b0;
        if (pop_fire) begin
            x_d      = fifo_head.x;
            y_d      = fifo_head.y[VGA_Y_W-1:0];
            colour_d = fifo_head.colour;
            frame_d  = (fifo_head.x == COORD_W'(X_MAX)) && (fifo_head.y == COORD_W'(Y_MAX));
        end
    end

    // Output and control state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            frame_q  <= 1'b0;
`ifdef PLOT_WRITER_CLIP_EN
            drop_q   <= '0;
`endif
        end else begin
            run_q    <= run_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            frame_q  <= frame_d;
`ifdef PLOT_WRITER_CLIP_EN
            drop_q   <= drop_d;
`endif
        end
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_q;
    assign vga_plot   = plot_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_plot_writer.sv
// Directed bench for plot_writer with a pixel-order scoreboard.
// Define PLOT_WRITER_CLIP_EN to also exercise clipping.
module tb_plot_writer;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  in_x, in_y;
    logic [11:0] in_color;
    logic        in_valid, in_ready, vga_ready;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [11:0] vga_colour;
    logic        vga_plot, frame_done;
`ifdef PLOT_WRITER_CLIP_EN
    logic [7:0]  drop_count;
`endif

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_plot = 0, n_frame = 0, last_plot_cyc = 0;
    pixel_t exp_q[$];
    pixel_t exp_pix;
    logic   exp_plot = 1'b0;

    plot_writer dut (
        .clk(clk), .resetn(resetn), .in_x(in_x), .in_y(in_y), .in_color(in_color),
        .in_valid(in_valid), .in_ready(in_ready), .vga_ready(vga_ready),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .frame_done(frame_done)
`ifdef PLOT_WRITER_CLIP_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
        in_valid = v; in_x = x; in_y = y; in_color = c;
    endtask

    function automatic logic clipped(input logic [7:0] x, input logic [7:0] y);
`ifdef PLOT_WRITER_CLIP_EN
        return (x > 8'd159) || (y > 8'd119);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: check last edge's predicted plot, then predict the coming edge.
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            exp_plot = 1'b0;
        end else begin
            chk("plot", {31'd0, vga_plot}, {31'd0, exp_plot});
            chk("frame_done", {31'd0, frame_done},
                {31'd0, exp_plot && exp_pix.x == 8'd159 && exp_pix.y == 8'd119});
            if (exp_plot) begin
                chk("sb_x", {24'd0, vga_x}, {24'd0, exp_pix.x});
                chk("sb_y", {25'd0, vga_y}, {25'd0, exp_pix.y[6:0]});
                chk("sb_colour", {20'd0, vga_colour}, {20'd0, exp_pix.colour});
            end
            if (vga_plot) begin n_plot++; last_plot_cyc = cyc; end
            if (frame_done) n_frame++;
            exp_plot = (exp_q.size() > 0) && vga_ready;
            if (exp_plot) exp_pix = exp_q.pop_front();
            if (in_valid && in_ready && !clipped(in_x, in_y))
                exp_q.push_back('{x: in_x, y: in_y, colour: in_color});
        end
    end

    initial begin
        int p0, f0, c0, sent, stalls, guard;
        resetn = 1'b1; vga_ready = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 12'd0);
        #2 resetn = 1'b0;
        #1;
        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_plot", {31'd0, vga_plot}, 32'd0);
        chk("rst_frame", {31'd0, frame_done}, 32'd0);
        chk("rst_xyc", {5'd0, vga_x, vga_y, vga_colour}, 32'd0);
        tick(2);
        resetn = 1'b1;
        chk("ready_before_edge", {31'd0, in_ready}, 32'd0);
        tick();
        chk("ready_after_edge", {31'd0, in_ready}, 32'd1);

        // Latency: accept at edge N, plot visible after N+1
        vga_ready = 1'b1;
        drive(1'b1, 8'd5, 8'd7, 12'hF00);
        tick();
        drive(1'b0, 8'd0, 8'd0, 12'd0);
        chk("lat_plot_n", {31'd0, vga_plot}, 32'd0);
        tick();
        chk("lat_plot_n1", {31'd0, vga_plot}, 32'd1);
        chk("lat_x", {24'd0, vga_x}, 32'd5);
        chk("lat_y", {25'd0, vga_y}, 32'd7);
        chk("lat_colour", {20'd0, vga_colour}, 32'hF00);
        tick();
        chk("lat_plot_off", {31'd0, vga_plot}, 32'd0);
        chk("lat_hold_x", {24'd0, vga_x}, 32'd5);

        // Full FIFO, then drain in order
        vga_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(i + 1), 8'(i + 20), 12'(12'h111 * (i + 1)));
            tick();
        end
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 8'd99, 8'd99, 12'h999);
        tick();
        chk("full_ready_hold", {31'd0, in_ready}, 32'd0);
        chk("full_no_plot", {31'd0, vga_plot}, 32'd0);
        drive(1'b0, 8'd0, 8'd0, 12'd0);
        vga_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_plot", {31'd0, vga_plot}, 32'd1);
            chk("drain_x", {24'd0, vga_x}, 32'(i + 1));
            chk("drain_colour", {20'd0, vga_colour}, 32'(12'h111 * (i + 1)));
        end
        chk("drain_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("drain_done", {31'd0, vga_plot}, 32'd0);

        // Backpressure: vga_ready toggles every cycle
        p0 = n_plot; sent = 0;
        for (int k = 0; k < 40; k++) begin
            vga_ready = k[0];
            if (sent < 8) drive(1'b1, 8'(sent * 3), 8'(sent + 100), 12'(12'hA00 + sent));
            else          drive(1'b0, 8'd0, 8'd0, 12'd0);
            if (in_valid && in_ready) sent++;
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 12'd0);
        vga_ready = 1'b1;
        tick(4);
        chk("bp_sent", 32'(sent), 32'd8);
        chk("bp_plots", 32'(n_plot - p0), 32'd8);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Mid-operation reset with 3 pixels queued
        vga_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(i + 40), 8'd3, 12'h0F0);
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 12'd0);
        resetn = 1'b0;
        #1;
        chk("mrst_ready", {31'd0, in_ready}, 32'd0);
        chk("mrst_plot", {31'd0, vga_plot}, 32'd0);
        chk("mrst_xyc", {5'd0, vga_x, vga_y, vga_colour}, 32'd0);
        tick(2);
        resetn = 1'b1;
        p0 = n_plot;
        vga_ready = 1'b1;
        tick();
        chk("mrst_ready_rel", {31'd0, in_ready}, 32'd1);
        tick(10);
        chk("mrst_no_plots", 32'(n_plot - p0), 32'd0);

        // Full frame streamed at one pixel per clock
        p0 = n_plot; f0 = n_frame; stalls = 0; c0 = cyc;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                drive(1'b1, 8'(x), 8'(y), 12'(x ^ (y << 4)));
                guard = 0;
                while (!in_ready && guard < 100) begin tick(); stalls++; guard++; end
                tick();
            end
        end
        drive(1'b0, 8'd0, 8'd0, 12'd0);
        tick(4);
        chk("frame_plots", 32'(n_plot - p0), 32'd19200);
        chk("frame_stalls", 32'(stalls), 32'd0);
        chk("frame_done_cnt", 32'(n_frame - f0), 32'd1);
        chk("frame_last_cyc", 32'(last_plot_cyc - c0), 32'd19201);
        chk("frame_last_x", {24'd0, vga_x}, 32'd159);
        chk("frame_last_y", {25'd0, vga_y}, 32'd119);

`ifdef PLOT_WRITER_CLIP_EN
        // Clipping of off-screen pixels
        p0 = n_plot; f0 = n_frame;
        chk("clip_drop0", {24'd0, drop_count}, 32'd0);
        drive(1'b1, 8'd160, 8'd0, 12'h123);
        tick();
        drive(1'b1, 8'd0, 8'd120, 12'h456);
        tick();
        drive(1'b0, 8'd0, 8'd0, 12'd0);
        tick(3);
        chk("clip_no_plot", 32'(n_plot - p0), 32'd0);
        chk("clip_drop2", {24'd0, drop_count}, 32'd2);
        drive(1'b1, 8'd159, 8'd119, 12'hABC);
        tick();
        drive(1'b0, 8'd0, 8'd0, 12'd0);
        tick(3);
        chk("clip_edge_plot", 32'(n_plot - p0), 32'd1);
        chk("clip_edge_frame", 32'(n_frame - f0), 32'd1);
        chk("clip_drop_hold", {24'd0, drop_count}, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
